// File: rtl/reg_file.sv
// reg_file: 2**ADDR_W x DATA_W register file, two async reads, one write.
// Register 0 is hard-wired to zero.
//
// Ports:
//   reg1o, reg2o : read data, ports 1 and 2 (combinational)
//   reg1n, reg2n : read indices, ports 1 and 2
//   wregn, wdata : write index and data
//   wen          : write enable, active-high
//   clk          : clock, rising edge
//   reset        : synchronous clear, active-low
//
// Build option: define REGFILE_BYPASS_EN to forward wdata to a read
// port whose index matches a write taking effect on the next edge.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  output logic [DATA_W-1:0] reg1o,
  output logic [DATA_W-1:0] reg2o,
  input  logic [ADDR_W-1:0] reg1n,
  input  logic [ADDR_W-1:0] reg2n,
  input  logic [ADDR_W-1:0] wregn,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wen,
  input  logic              clk,
  input  logic              reset
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_go;

  // Strict compare keeps an X enable from writing.
  assign wr_go = (wen === 1'b1) && (wregn != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_go) begin
      regs[wregn] <= wdata;
    end
  end

  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Index 0 is forced so it never depends on array contents.
  assign rd1 = (reg1n == '0) ? '0 : regs[reg1n];
  assign rd2 = (reg2n == '0) ? '0 : regs[reg2n];

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;

  assign fwd_ok = wr_go && reset;

  always_comb begin
    reg1o = rd1;
    reg2o = rd2;
    if (fwd_ok && (reg1n == wregn))
      reg1o = wdata;
    if (fwd_ok && (reg2n == wregn))
      reg2o = wdata;
  end
`else
  always_comb begin
    reg1o = rd1;
    reg2o = rd2;
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed + randomized self-checking bench for reg_file.
// Reference is a plain array updated by the register-file rules.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic [DW-1:0] reg1o;
  logic [DW-1:0] reg2o;
  logic [AW-1:0] reg1n;
  logic [AW-1:0] reg2n;
  logic [AW-1:0] wregn;
  logic [DW-1:0] wdata;
  logic          wen;
  logic          clk;
  logic          reset;

  int checks;
  int errors;

  logic [DW-1:0] mdl [N];

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .reg1o(reg1o),
    .reg2o(reg2o),
    .reg1n(reg1n),
    .reg2n(reg2n),
    .wregn(wregn),
    .wdata(wdata),
    .wen(wen),
    .clk(clk),
    .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected combinational read given the current inputs.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] idx);
    logic [DW-1:0] v;
    v = (idx == 0) ? '0 : mdl[idx];
`ifdef REGFILE_BYPASS_EN
    if (reset && wen && wregn != 0 && wregn == idx)
      v = wdata;
`endif
    return v;
  endfunction

  // Advance one rising edge and apply the same edge to the model.
  task automatic tick();
    logic          r;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    r = reset; w = wen; a = wregn; d = wdata;
    @(posedge clk);
    #1;
    if (!r) begin
      for (int i = 0; i < N; i++) mdl[i] = '0;
    end else if (w && a != 0) begin
      mdl[a] = d;
    end
  endtask

  task automatic read_both(input string tag, input int idx);
    reg1n = AW'(idx);
    reg2n = AW'(idx);
    #1;
    check({tag, "_p1"}, reg1o, exp_rd(reg1n));
    check({tag, "_p2"}, reg2o, exp_rd(reg2n));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < N; i++) mdl[i] = 'x;
    reset = 1'b0;
    wen   = 1'b0;
    wregn = '0;
    wdata = '0;
    reg1n = '0;
    reg2n = '0;

    // Reset clears everything.
    @(negedge clk);
    tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      read_both("rst_clear", i);
      check("rst_const", reg1o, '0);
    end

    // Write reg[i] = i, then read back all.
    wen = 1'b1;
    for (int i = 1; i < N; i++) begin
      wregn = AW'(i);
      wdata = DW'(i);
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < N; i++) begin
      read_both("wr_seq", i);
      check("wr_seq_const", reg2o, DW'(i));
    end

    // Write to index 0 is ignored.
    wen = 1'b1; wregn = '0; wdata = 32'hDEADBEEF;
    tick();
    wen = 1'b0;
    read_both("zero_wr", 0);
    check("zero_const", reg1o, '0);

    // wen=0 leaves reg[5] alone.
    wregn = 5; wdata = 32'h1234;
    tick();
    read_both("wen0", 5);
    check("wen0_const", reg1o, 32'd5);

    // Reset beats a concurrent write.
    reset = 1'b0; wen = 1'b1; wregn = 7; wdata = 32'hFF;
    tick();
    reset = 1'b1; wen = 1'b0;
    read_both("rst_prio", 7);
    check("rst_prio_const", reg1o, '0);
    read_both("rst_prio5", 5);

    // Same-cycle read of the register being written.
    wen = 1'b1; wregn = 9; wdata = 32'h9;
    tick();
    wen = 1'b0;
    reg1n = 9; reg2n = 9;
    wen = 1'b1; wdata = 32'hA5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rw_same_pre", reg1o, 32'hA5);
`else
    check("rw_same_pre", reg1o, 32'h9);
`endif
    check("rw_same_pre_p2", reg2o, exp_rd(9));
    tick();
    wen = 1'b0;
    #1;
    check("rw_same_post1", reg1o, 32'hA5);
    check("rw_same_post2", reg2o, 32'hA5);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 24) != 0);
      wen   = 1'($urandom);
      wregn = AW'($urandom);
      wdata = $urandom;
      reg1n = ($urandom_range(0, 3) == 0) ? wregn : AW'($urandom);
      reg2n = ($urandom_range(0, 3) == 0) ? reg1n : AW'($urandom);
      #1;
      check("rand_p1", reg1o, exp_rd(reg1n));
      check("rand_p2", reg2o, exp_rd(reg2n));
      tick();
      wen = 1'b0;
      #1;
      check("rand_post1", reg1o, exp_rd(reg1n));
      check("rand_post2", reg2o, exp_rd(reg2n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
